// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared writeback encodings, load funct3 codes and WB register layout.
package wb_stage_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'b00,
        WB_SEL_LOAD = 2'b01,
        WB_SEL_PC4  = 2'b10,
        WB_SEL_RSV  = 2'b11
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic            valid;
        logic            rd_wen;
        logic [4:0]      rd_addr;
        wb_sel_e         sel;
        logic [2:0]      funct3;
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] pc4;
    } wb_reg_t;

endpackage

// File: rtl/wb_stage_if.sv
// wb_stage_if: MEM-side inputs and regfile-side outputs of the writeback stage.
interface wb_stage_if #(parameter int CNT_W = 64);
    import wb_stage_pkg::*;

    logic            mem_valid;
    logic            mem_rd_wen;
    logic [4:0]      mem_rd_addr;
    logic [1:0]      mem_wb_sel;
    logic [2:0]      mem_funct3;
    logic [XLEN-1:0] mem_alu_result;
    logic [XLEN-1:0] mem_pc_plus4;
    logic            mem_stall;
    logic            mem_flush;
    logic [XLEN-1:0] dmem_rdata;
    logic            wb_wen;
    logic [4:0]      wb_rd_addr;
    logic [XLEN-1:0] wb_wdata;
    logic            wb_valid;
    logic            wb_load_err;
    logic [CNT_W-1:0] wb_instret;

    modport master (
        output mem_valid, mem_rd_wen, mem_rd_addr, mem_wb_sel, mem_funct3,
               mem_alu_result, mem_pc_plus4, mem_stall, mem_flush, dmem_rdata,
        input  wb_wen, wb_rd_addr, wb_wdata, wb_valid, wb_load_err, wb_instret
    );

    modport slave (
        input  mem_valid, mem_rd_wen, mem_rd_addr, mem_wb_sel, mem_funct3,
               mem_alu_result, mem_pc_plus4, mem_stall, mem_flush, dmem_rdata,
        output wb_wen, wb_rd_addr, wb_wdata, wb_valid, wb_load_err, wb_instret
    );

endinterface

// File: rtl/wb_stage_load_align.sv
// wb_stage_load_align: extracts and extends a load from a RAM word; flags misaligned/illegal funct3.
module wb_stage_load_align
    import wb_stage_pkg::*;
(
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      offset_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] data_o,
    output logic            misaligned_o,
    output logic            illegal_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = offset_i == 2'd0 ? rdata_i[7:0]   :
                   offset_i == 2'd1 ? rdata_i[15:8]  :
                   offset_i == 2'd2 ? rdata_i[23:16] : rdata_i[31:24];
        half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        data_o       = '0;
        misaligned_o = 1'b0;
        illegal_o    = 1'b0;
        case (funct3_i)
            F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data_o = {24'd0, byte_sel};
            F3_LH: begin
                data_o       = {{16{half_sel[15]}}, half_sel};
                misaligned_o = offset_i[0];
            end
            F3_LHU: begin
                data_o       = {16'd0, half_sel};
                misaligned_o = offset_i[0];
            end
            F3_LW: begin
                data_o       = rdata_i;
                misaligned_o = |offset_i;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: MEM->WB pipeline register, writeback mux, load error flag and retired-instruction counter.
module wb_stage #(
    parameter int CNT_W = 64
) (
    input logic       clk,
    input logic       reset,
    wb_stage_if.slave bus
);
    import wb_stage_pkg::*;

    wb_reg_t          wb_q, wb_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [XLEN-1:0]  ld_data;
    logic             ld_mis, ld_ill, load_err, retire;

    wb_stage_load_align u_align (
        .funct3_i     (wb_q.funct3),
        .offset_i     (wb_q.result[1:0]),
        .rdata_i      (bus.dmem_rdata),
        .data_o       (ld_data),
        .misaligned_o (ld_mis),
        .illegal_o    (ld_ill)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_q      <= '0;
            instret_q <= '0;
        end else begin
            wb_q      <= wb_d;
            instret_q <= instret_d;
        end
    end

    // Flush only kills valid/rd_wen; the payload is held so the bubble is cheap.
    always_comb begin
        wb_d = wb_q;
        if (bus.mem_flush) begin
            wb_d.valid  = 1'b0;
            wb_d.rd_wen = 1'b0;
        end else if (!bus.mem_stall) begin
            wb_d.valid   = bus.mem_valid;
            wb_d.rd_wen  = bus.mem_rd_wen;
            wb_d.rd_addr = bus.mem_rd_addr;
            wb_d.sel     = wb_sel_e'(bus.mem_wb_sel);
            wb_d.funct3  = bus.mem_funct3;
            wb_d.result  = bus.mem_alu_result;
            wb_d.pc4     = bus.mem_pc_plus4;
        end
        retire    = wb_q.valid & (~bus.mem_stall | bus.mem_flush);
        instret_d = instret_q + CNT_W'(retire);
    end

    always_comb begin
        load_err        = wb_q.valid & (wb_q.sel == WB_SEL_LOAD) & (ld_mis | ld_ill);
        bus.wb_wdata    = wb_q.sel == WB_SEL_ALU  ? wb_q.result :
                          wb_q.sel == WB_SEL_LOAD ? (load_err ? '0 : ld_data) :
                          wb_q.sel == WB_SEL_PC4  ? wb_q.pc4 : '0;
        bus.wb_wen      = wb_q.valid & wb_q.rd_wen & (|wb_q.rd_addr) & ~load_err &
                          (wb_q.sel != WB_SEL_RSV);
        bus.wb_rd_addr  = wb_q.rd_addr;
        bus.wb_valid    = wb_q.valid;
        bus.wb_load_err = load_err;
        bus.wb_instret  = instret_q;
    end

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: vector table through a scoreboard queue, plus stall/flush/async-reset sequences.
module tb_wb_stage;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wb_stage_if #(.CNT_W(64)) bus ();
    wb_stage #(.CNT_W(64)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic        valid, rd_wen;
        logic [4:0]  rd;
        logic [1:0]  sel;
        logic [2:0]  f3;
        logic [31:0] res, pc4, rdata;
        logic        e_wen;
        logic [31:0] e_wdata;
        logic        e_err;
    } vec_t;

    typedef struct {
        logic        valid, wen, err;
        logic [4:0]  rd;
        logic [31:0] wdata;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sb[$];
    exp_t        e;
    int          n_vec = 0, n_err = 0;
    logic        m_valid;
    logic [63:0] exp_cnt, base;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic w, input logic [4:0] rd, input logic [1:0] sel,
                         input logic [2:0] f3, input logic [31:0] res, input logic [31:0] pc4,
                         input logic [31:0] rdata);
        bus.mem_valid      = v;
        bus.mem_rd_wen     = w;
        bus.mem_rd_addr    = rd;
        bus.mem_wb_sel     = sel;
        bus.mem_funct3     = f3;
        bus.mem_alu_result = res;
        bus.mem_pc_plus4   = pc4;
        bus.dmem_rdata     = rdata;
    endtask

    // Advance one edge, updating the bench's own valid/instret model from the driven controls.
    task automatic step();
        @(posedge clk);
        if (m_valid && (!bus.mem_stall || bus.mem_flush)) exp_cnt++;
        if (bus.mem_flush) m_valid = 1'b0;
        else if (!bus.mem_stall) m_valid = bus.mem_valid;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        vecs.push_back('{1, 1, 5'd5, 2'b00, 3'b000, 32'h12345678, 32'h0, 32'h0, 1, 32'h12345678, 0});
        vecs.push_back('{1, 1, 5'd6, 2'b01, 3'b000, 32'h00001003, 32'h0, 32'h80FF7F01, 1, 32'hFFFFFF80, 0});
        vecs.push_back('{1, 1, 5'd7, 2'b01, 3'b100, 32'h00001001, 32'h0, 32'h80FF7F01, 1, 32'h0000007F, 0});
        vecs.push_back('{1, 1, 5'd8, 2'b01, 3'b001, 32'h00001002, 32'h0, 32'h80FF7F01, 1, 32'hFFFF80FF, 0});
        vecs.push_back('{1, 1, 5'd9, 2'b01, 3'b101, 32'h00001000, 32'h0, 32'h80FF7F01, 1, 32'h00007F01, 0});
        vecs.push_back('{1, 1, 5'd10, 2'b01, 3'b010, 32'h00001000, 32'h0, 32'h80FF7F01, 1, 32'h80FF7F01, 0});
        vecs.push_back('{1, 1, 5'd11, 2'b01, 3'b010, 32'h00001002, 32'h0, 32'h80FF7F01, 0, 32'h0, 1});
        vecs.push_back('{1, 1, 5'd12, 2'b01, 3'b001, 32'h00001001, 32'h0, 32'h80FF7F01, 0, 32'h0, 1});
        vecs.push_back('{1, 1, 5'd0, 2'b00, 3'b000, 32'h0000DEAD, 32'h0, 32'h0, 0, 32'h0000DEAD, 0});
        vecs.push_back('{1, 1, 5'd1, 2'b10, 3'b000, 32'h00000055, 32'h104, 32'h0, 1, 32'h00000104, 0});
        vecs.push_back('{1, 1, 5'd3, 2'b11, 3'b000, 32'h00000077, 32'h200, 32'h0, 0, 32'h0, 0});
        vecs.push_back('{1, 1, 5'd4, 2'b01, 3'b011, 32'h00001000, 32'h0, 32'h80FF7F01, 0, 32'h0, 1});
        vecs.push_back('{1, 1, 5'd13, 2'b00, 3'b011, 32'hCAFE0000, 32'h0, 32'h0, 1, 32'hCAFE0000, 0});
        vecs.push_back('{0, 1, 5'd5, 2'b00, 3'b000, 32'h0BADF00D, 32'h0, 32'h0, 0, 32'h0BADF00D, 0});
        vecs.push_back('{1, 0, 5'd5, 2'b00, 3'b000, 32'h00000042, 32'h0, 32'h0, 0, 32'h00000042, 0});
        vecs.push_back('{1, 1, 5'd14, 2'b01, 3'b000, 32'h00000000, 32'h0, 32'h80FF7F01, 1, 32'h00000001, 0});
        vecs.push_back('{1, 1, 5'd15, 2'b01, 3'b100, 32'h00000003, 32'h0, 32'h80FF7F01, 1, 32'h00000080, 0});

        reset = 1'b1;
        bus.mem_stall = 1'b0;
        bus.mem_flush = 1'b0;
        drive(1, 1, 5'd9, 2'b00, 3'b000, 32'h11111111, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(bus.wb_valid), 64'd0);
        chk("rst_wen", 64'(bus.wb_wen), 64'd0);
        chk("rst_rd", 64'(bus.wb_rd_addr), 64'd0);
        chk("rst_wdata", 64'(bus.wb_wdata), 64'd0);
        chk("rst_err", 64'(bus.wb_load_err), 64'd0);
        chk("rst_instret", bus.wb_instret, 64'd0);
        reset   = 1'b0;
        m_valid = 1'b0;
        exp_cnt = '0;

        foreach (vecs[i]) begin
            drive(vecs[i].valid, vecs[i].rd_wen, vecs[i].rd, vecs[i].sel, vecs[i].f3,
                  vecs[i].res, vecs[i].pc4, vecs[i].rdata);
            sb.push_back('{vecs[i].valid, vecs[i].e_wen, vecs[i].e_err, vecs[i].rd, vecs[i].e_wdata});
            step();
            e = sb.pop_front();
            chk($sformatf("v%0d_valid", i), 64'(bus.wb_valid), 64'(e.valid));
            chk($sformatf("v%0d_wen", i), 64'(bus.wb_wen), 64'(e.wen));
            chk($sformatf("v%0d_rd", i), 64'(bus.wb_rd_addr), 64'(e.rd));
            chk($sformatf("v%0d_wdata", i), 64'(bus.wb_wdata), 64'(e.wdata));
            chk($sformatf("v%0d_err", i), 64'(bus.wb_load_err), 64'(e.err));
            chk($sformatf("v%0d_instret", i), bus.wb_instret, exp_cnt);
        end

        // Stall three cycles while MEM presents a different instruction.
        drive(1, 1, 5'd7, 2'b00, 3'b000, 32'h000000AA, 32'h0, 32'h0);
        step();
        base = exp_cnt;
        bus.mem_stall = 1'b1;
        drive(1, 1, 5'd9, 2'b00, 3'b000, 32'h00000055, 32'h0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_rd", 64'(bus.wb_rd_addr), 64'd7);
            chk("stall_wdata", 64'(bus.wb_wdata), 64'hAA);
            chk("stall_wen", 64'(bus.wb_wen), 64'd1);
            chk("stall_instret", bus.wb_instret, base);
        end
        bus.mem_flush = 1'b1;
        step();
        chk("sflush_valid", 64'(bus.wb_valid), 64'd0);
        chk("sflush_wen", 64'(bus.wb_wen), 64'd0);
        chk("sflush_instret", bus.wb_instret, base + 64'd1);
        bus.mem_flush = 1'b0;
        bus.mem_stall = 1'b0;
        bus.mem_valid = 1'b0;
        step();
        chk("sflush_once", bus.wb_instret, base + 64'd1);
        chk("model_cnt", bus.wb_instret, exp_cnt);

        // Flush alone drops an incoming valid instruction.
        bus.mem_valid = 1'b1;
        bus.mem_flush = 1'b1;
        step();
        chk("flush_valid", 64'(bus.wb_valid), 64'd0);
        chk("flush_wen", 64'(bus.wb_wen), 64'd0);
        bus.mem_flush = 1'b0;

        // Async reset mid-cycle with a valid instruction in WB.
        drive(1, 1, 5'd4, 2'b00, 3'b000, 32'h00000044, 32'h0, 32'h0);
        step();
        step();
        chk("pre_rst_instret", bus.wb_instret, exp_cnt);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid", 64'(bus.wb_valid), 64'd0);
        chk("arst_wen", 64'(bus.wb_wen), 64'd0);
        chk("arst_instret", bus.wb_instret, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        bus.mem_valid = 1'b0;
        m_valid = 1'b0;
        exp_cnt = '0;
        step();
        chk("post_rst_wen", 64'(bus.wb_wen), 64'd0);
        chk("post_rst_valid", 64'(bus.wb_valid), 64'd0);
        chk("post_rst_instret", bus.wb_instret, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
MEM->WB pipeline register plus writeback mux for the mini RISC-V core. Captures the retiring instruction from the MEM stage and aligns and extends load data from the synchronous data RAM. Drives the register file write port (wen/waddr/wdata) and reports misaligned or illegal loads. Also keeps a 64-bit retired-instruction counter.

Parameters:
XLEN, 32, datapath width (only 32 supported)
CNT_W, 64, width of retired-instruction counter

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
mem_valid  in  1  MEM stage holds a real instruction
mem_rd_wen  in  1  instruction writes rd
mem_rd_addr  in  5  destination register
mem_wb_sel  in  2  00 ALU result, 01 load data, 10 PC+4, 11 reserved
mem_funct3  in  3  load width/sign field
mem_alu_result  in  32  ALU result / load effective address
mem_pc_plus4  in  32  link value
mem_stall  in  1  freeze WB register
mem_flush  in  1  insert bubble into WB
dmem_rdata  in  32  sync RAM read word for address presented in MEM last edge
wb_wen  out  1  regfile write enable
wb_rd_addr  out  5  regfile write address
wb_wdata  out  32  regfile write data
wb_valid  out  1  WB holds a real instruction
wb_load_err  out  1  misaligned/illegal load in WB
wb_instret  out  CNT_W  retired instruction count

Behaviour:
- Reset (async): WB register cleared; wb_valid=0, wb_rd_addr=0, stored wb_sel/funct3/result/pc=0; wb_instret=0. Outputs derived: wb_wen=0, wb_wdata=0, wb_load_err=0.
- Register update each posedge, priority: flush > stall > load.
  - mem_flush=1: wb_valid<=0 and rd_wen<=0; other fields don't-care, but hold them.
  - mem_stall=1 (no flush): all WB fields hold.
  - Else: capture all mem_* fields; wb_valid<=mem_valid.
- Latency: MEM to regfile write = 1 cycle. Regfile write happens on the following edge; same-cycle read bypass is inside the regfile.
- Load alignment is combinational on registered offset = result[1:0] and dmem_rdata:
  - LB (000) / LBU (100): byte at offset, sign- or zero-extended.
  - LH (001) / LHU (101): half at offset[1]. offset[0]=1 is misaligned.
  - LW (010): whole word. offset!=0 is misaligned.
  - funct3 011/110/111: illegal.
- wb_load_err = wb_valid & (sel==01) & (misaligned|illegal).
- wb_wdata mux: sel 00 result; 01 aligned load (0 when load_err); 10 pc_plus4; 11 gives 0.
- wb_wen = wb_valid & rd_wen & (rd_addr!=0) & ~wb_load_err & (sel!=11). x0 is never written.
- dmem_rdata is valid for the WB instruction every cycle it is held. The RAM re-reads its held address during stall, so a stalled load rewrites an identical value (idempotent).
- Retire pulse = wb_valid & (~mem_stall | mem_flush), i.e. the instruction leaves WB this edge. wb_instret += 1 on each pulse and wraps modulo 2^CNT_W. Instructions with wb_load_err still retire (trap handling lives elsewhere).
- Reset mid-stall or mid-load: everything clears immediately; no write is issued after reset deasserts until a new valid capture.

Decomposition:
- Shared package (core_pkg): WB_SEL_ALU/LOAD/PC4 encodings, funct3 load constants (F3_LB/LH/LW/LBU/LHU), XLEN.
- One sub-module: load_align (combinational: funct3, offset, rdata -> data, misaligned, illegal). It is reused by any future LSU.

Test Plan:
- ALU writeback: mem_valid=1, rd=5, sel=00, result=0x12345678 -> next cycle wb_wen=1, wb_rd_addr=5, wb_wdata=0x12345678; instret 0->1 on following edge.
- Loads from word 0x80FF7F01: LB off3 -> 0xFFFFFF80; LBU off1 -> 0x0000007F; LH off2 -> 0xFFFF80FF; LHU off0 -> 0x00007F01; LW off0 -> 0x80FF7F01.
- Misaligned: LW off=2 or LH off=1 -> wb_load_err=1, wb_wen=0, wb_wdata=0; instret still increments.
- x0 and JAL link: rd=0, sel=00 -> wb_wen=0. rd=1, sel=10, pc_plus4=0x104 -> wb_wdata=0x104.
- Stall/flush: stall 3 cycles -> outputs held, instret unchanged; stall+flush same cycle -> wb_valid=0 next cycle, held instruction counted once.
- Async reset asserted mid-cycle with wb_valid=1 -> wb_valid, wb_wen and wb_instret go to 0 before the next clock edge.
